// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared encodings and constants for the SD CMD-line blocks
`timescale 1ns/1ps

package sd_pkg;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_R1   = 2'd1,
        RESP_R3   = 2'd2,
        RESP_R2   = 2'd3
    } resp_type_t;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_START = 2'd1,
        ST_RECEIVE    = 2'd2,
        ST_REPORT     = 2'd3
    } rx_state_t;

    // x^7 + x^3 + 1, with the x^7 term implicit
    localparam logic [6:0] CRC7_POLY = 7'h09;

    localparam int FRAME_LEN_SHORT = 48;
    localparam int FRAME_LEN_R2    = 136;

endpackage

// File: rtl/sd_crc7.sv
// rtl/sd_crc7.sv - serial CRC7 (zero seed), one bit per enabled cycle, MSB first
`timescale 1ns/1ps

module sd_crc7
    import sd_pkg::*;
(
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    logic fb;

    assign fb = din ^ crc[6];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            crc <= '0;
        end else if (clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
        end
    end

endmodule

// File: rtl/sd_cmd_resp_rx.sv
// rtl/sd_cmd_resp_rx.sv - SD CMD-line response receiver; SD_R2_LONG_EN enables 136-bit R2 frames
`timescale 1ns/1ps

module sd_cmd_resp_rx
    import sd_pkg::*;
#(
    parameter int NCR_MAX = 64,
    parameter int CNT_W   = 8
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         SAMPLE_EN,
    input  logic         CMD_IN,
    input  logic         START,
    input  logic [1:0]   RESP_TYPE,
    input  logic [5:0]   EXP_INDEX,
    output logic         BUSY,
    output logic         DONE,
    output logic [135:0] RESP,
    output logic         TIMEOUT,
    output logic         CRC_ERR,
    output logic         FRAME_ERR,
    output logic         INDEX_ERR
);

`ifdef SD_R2_LONG_EN
    localparam int RESP_W = FRAME_LEN_R2;
`else
    localparam int RESP_W = FRAME_LEN_SHORT;
`endif

    localparam logic [CNT_W-1:0] NCR_LAST   = CNT_W'(NCR_MAX - 1);
    localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(FRAME_LEN_SHORT - 1);

    rx_state_t         state;
    resp_type_t        type_q;
    logic [5:0]        exp_idx_q;
    logic [RESP_W-1:0] resp_q;
    logic [RESP_W-1:0] resp_shift;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  ncr_cnt;
    logic              busy_q;
    logic              done_q;
    logic              timeout_q;
    logic              crc_err_q;
    logic              frame_err_q;
    logic              index_err_q;

    logic              crc_clr;
    logic              crc_en;
    logic [6:0]        crc;
    logic              last_bit;
    logic              chk_frame;
    logic              chk_index;
    logic              chk_crc;

    assign resp_shift = {resp_q[RESP_W-2:0], CMD_IN};

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign TIMEOUT   = timeout_q;
    assign CRC_ERR   = crc_err_q;
    assign FRAME_ERR = frame_err_q;
    assign INDEX_ERR = index_err_q;

`ifdef SD_R2_LONG_EN
    assign RESP     = resp_q;
    assign last_bit = (type_q == RESP_R2) ? (bit_cnt == CNT_W'(FRAME_LEN_R2 - 1))
                                          : (bit_cnt == SHORT_LAST);
`else
    assign RESP     = {88'd0, resp_q};
    assign last_bit = (bit_cnt == SHORT_LAST);
`endif

    // CRC covers frame bits [47:8] (short) or [127:8] (R2); bit_cnt is the number already received
    assign crc_clr = (state == ST_IDLE) && START;

    always_comb begin
        crc_en = 1'b0;
        if (SAMPLE_EN) begin
            case (state)
                ST_WAIT_START: crc_en = !CMD_IN && (type_q != RESP_R2);
                ST_RECEIVE: begin
                    if (type_q == RESP_R2)
                        crc_en = (bit_cnt >= CNT_W'(8)) && (bit_cnt <= CNT_W'(127));
                    else
                        crc_en = (bit_cnt <= CNT_W'(39));
                end
                default: crc_en = 1'b0;
            endcase
        end
    end

    sd_crc7 u_crc7 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .clr   (crc_clr),
        .en    (crc_en),
        .din   (CMD_IN),
        .crc   (crc)
    );

    // Checks look at the frame as it will be after the end bit shifts in
    always_comb begin
        chk_frame = resp_shift[46] | ~resp_shift[0];
        chk_index = resp_shift[45:40] != ((type_q == RESP_R1) ? exp_idx_q : 6'h3F);
        chk_crc   = (type_q == RESP_R1) && (crc != resp_shift[7:1]);
`ifdef SD_R2_LONG_EN
        if (type_q == RESP_R2) begin
            chk_frame = resp_shift[134] | ~resp_shift[0];
            chk_index = resp_shift[133:128] != 6'h3F;
            chk_crc   = crc != resp_shift[7:1];
        end
`endif
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= ST_IDLE;
            type_q      <= RESP_NONE;
            exp_idx_q   <= '0;
            resp_q      <= '0;
            bit_cnt     <= '0;
            ncr_cnt     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            index_err_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        type_q      <= resp_type_t'(RESP_TYPE);
                        exp_idx_q   <= EXP_INDEX;
                        resp_q      <= '0;
                        bit_cnt     <= '0;
                        ncr_cnt     <= '0;
                        busy_q      <= 1'b1;
                        timeout_q   <= 1'b0;
                        crc_err_q   <= 1'b0;
                        frame_err_q <= 1'b0;
                        index_err_q <= 1'b0;
                        if (RESP_TYPE == RESP_NONE) begin
                            state  <= ST_REPORT;
                            done_q <= 1'b1;
`ifndef SD_R2_LONG_EN
                        end else if (RESP_TYPE == RESP_R2) begin
                            frame_err_q <= 1'b1;
                            state       <= ST_REPORT;
                            done_q      <= 1'b1;
`endif
                        end else begin
                            state <= ST_WAIT_START;
                        end
                    end
                end
                ST_WAIT_START: begin
                    if (SAMPLE_EN) begin
                        if (!CMD_IN) begin
                            resp_q  <= resp_shift;
                            bit_cnt <= CNT_W'(1);
                            state   <= ST_RECEIVE;
                        end else if (ncr_cnt == NCR_LAST) begin
                            timeout_q <= 1'b1;
                            state     <= ST_REPORT;
                            done_q    <= 1'b1;
                        end else begin
                            ncr_cnt <= ncr_cnt + 1'b1;
                        end
                    end
                end
                ST_RECEIVE: begin
                    if (SAMPLE_EN) begin
                        resp_q <= resp_shift;
                        if (bit_cnt != '1)
                            bit_cnt <= bit_cnt + 1'b1;
                        if (last_bit) begin
                            frame_err_q <= chk_frame;
                            index_err_q <= chk_index;
                            crc_err_q   <= chk_crc;
                            state       <= ST_REPORT;
                            done_q      <= 1'b1;
                        end
                    end
                end
                ST_REPORT: begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_resp_rx.sv
// tb/tb_sd_cmd_resp_rx.sv - directed self-checking bench for sd_cmd_resp_rx
`timescale 1ns/1ps

module tb_sd_cmd_resp_rx;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         SAMPLE_EN = 1'b0;
    logic         CMD_IN = 1'b1;
    logic         START = 1'b0;
    logic [1:0]   RESP_TYPE = 2'd0;
    logic [5:0]   EXP_INDEX = 6'd0;
    logic         BUSY;
    logic         DONE;
    logic [135:0] RESP;
    logic         TIMEOUT;
    logic         CRC_ERR;
    logic         FRAME_ERR;
    logic         INDEX_ERR;

    int checks = 0;
    int errors = 0;

    localparam logic [47:0] R7_OK  = 48'h08_0000_01AA_13;
    localparam logic [47:0] R7_BAD = 48'h08_0000_01AA_15;
    localparam logic [47:0] R3_OK  = 48'h3F_00FF_8000_FF;

    always #5 CLK = ~CLK;

    sd_cmd_resp_rx #(.NCR_MAX(64), .CNT_W(8)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .SAMPLE_EN (SAMPLE_EN),
        .CMD_IN    (CMD_IN),
        .START     (START),
        .RESP_TYPE (RESP_TYPE),
        .EXP_INDEX (EXP_INDEX),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .RESP      (RESP),
        .TIMEOUT   (TIMEOUT),
        .CRC_ERR   (CRC_ERR),
        .FRAME_ERR (FRAME_ERR),
        .INDEX_ERR (INDEX_ERR)
    );

    function automatic logic [6:0] crc7_of120(input logic [119:0] d);
        logic [6:0] c;
        logic       fb;
        c = 7'h00;
        for (int i = 119; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    task automatic strobe(input logic b);
        @(negedge CLK);
        CMD_IN = b;
        SAMPLE_EN = 1'b1;
        @(posedge CLK);
        #1;
        SAMPLE_EN = 1'b0;
        CMD_IN = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    // Last strobe returns #1 after its sampling edge so DONE can be checked right away
    task automatic last_strobe(input logic b);
        @(negedge CLK);
        CMD_IN = b;
        SAMPLE_EN = 1'b1;
        @(posedge CLK);
        #1;
        SAMPLE_EN = 1'b0;
        CMD_IN = 1'b1;
    endtask

    task automatic start_cmd(input logic [1:0] t, input logic [5:0] idx);
        @(negedge CLK);
        START = 1'b1;
        RESP_TYPE = t;
        EXP_INDEX = idx;
        @(posedge CLK);
        #1;
        START = 1'b0;
    endtask

    task automatic send_frame(input logic [135:0] f, input int len);
        int early;
        early = 0;
        for (int i = len - 1; i >= 1; i--) begin
            strobe(f[i]);
            if (DONE) early++;
        end
        checks++;
        if (early !== 0) begin
            errors++;
            $display("FAIL early_done: got %0d early DONE cycles, expected 0", early);
        end
        last_strobe(f[0]);
    endtask

    task automatic check_result(input string name, input logic [135:0] exp_resp,
                                input logic exp_to, input logic exp_crc,
                                input logic exp_frm, input logic exp_idx);
        checks++;
        if (DONE !== 1'b1) begin
            errors++;
            $display("FAIL %s done: got %b expected 1", name, DONE);
        end
        checks++;
        if (RESP !== exp_resp) begin
            errors++;
            $display("FAIL %s resp: got %h expected %h", name, RESP, exp_resp);
        end
        checks++;
        if ({TIMEOUT, CRC_ERR, FRAME_ERR, INDEX_ERR} !== {exp_to, exp_crc, exp_frm, exp_idx}) begin
            errors++;
            $display("FAIL %s flags(to,crc,frm,idx): got %b expected %b", name,
                     {TIMEOUT, CRC_ERR, FRAME_ERR, INDEX_ERR}, {exp_to, exp_crc, exp_frm, exp_idx});
        end
        checks++;
        if (BUSY !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_at_done: got %b expected 1", name, BUSY);
        end
        @(posedge CLK);
        #1;
        checks++;
        if ({DONE, BUSY} !== 2'b00) begin
            errors++;
            $display("FAIL %s after_done(done,busy): got %b expected 00", name, {DONE, BUSY});
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({BUSY, DONE, TIMEOUT, CRC_ERR, FRAME_ERR, INDEX_ERR} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {BUSY, DONE, TIMEOUT, CRC_ERR, FRAME_ERR, INDEX_ERR});
        end
        checks++;
        if (RESP !== 136'd0) begin
            errors++;
            $display("FAIL reset_resp: got %h expected 0", RESP);
        end
    endtask

    task automatic test_r7_pass();
        start_cmd(2'd1, 6'd8);
        checks++;
        if (BUSY !== 1'b1) begin
            errors++;
            $display("FAIL r7_busy_after_start: got %b expected 1", BUSY);
        end
        for (int i = 0; i < 5; i++) strobe(1'b1);
        send_frame({88'd0, R7_OK}, 48);
        check_result("r7_pass", {88'd0, R7_OK}, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_idle_ignored();
        for (int i = 0; i < 3; i++) strobe(1'b0);
        checks++;
        if ({BUSY, RESP} !== {1'b0, 88'd0, R7_OK}) begin
            errors++;
            $display("FAIL idle_sample_ignored: got busy=%b resp=%h expected busy=0 resp=%h",
                     BUSY, RESP, R7_OK);
        end
    endtask

    task automatic test_crc_err();
        start_cmd(2'd1, 6'd8);
        for (int i = 0; i < 5; i++) strobe(1'b1);
        send_frame({88'd0, R7_BAD}, 48);
        check_result("crc_err", {88'd0, R7_BAD}, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_index_err();
        start_cmd(2'd1, 6'd9);
        strobe(1'b1);
        send_frame({88'd0, R7_OK}, 48);
        check_result("index_err", {88'd0, R7_OK}, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_timeout();
        start_cmd(2'd1, 6'd8);
        checks++;
        if ({RESP, CRC_ERR, INDEX_ERR} !== 138'd0) begin
            errors++;
            $display("FAIL start_clears: got resp=%h crc=%b idx=%b expected all 0",
                     RESP, CRC_ERR, INDEX_ERR);
        end
        for (int i = 0; i < 63; i++) strobe(1'b1);
        checks++;
        if ({DONE, BUSY, TIMEOUT} !== 3'b010) begin
            errors++;
            $display("FAIL timeout_63(done,busy,to): got %b expected 010", {DONE, BUSY, TIMEOUT});
        end
        last_strobe(1'b1);
        check_result("timeout", 136'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_r3();
        start_cmd(2'd2, 6'd0);
        strobe(1'b1);
        send_frame({88'd0, R3_OK}, 48);
        check_result("r3", {88'd0, R3_OK}, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        int seen;
        start_cmd(2'd2, 6'd0);
        for (int i = 47; i >= 27; i--) strobe(R3_OK[i]);
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        checks++;
        if ({BUSY, DONE, TIMEOUT, CRC_ERR, FRAME_ERR, INDEX_ERR} !== 6'b0 || RESP !== 136'd0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b done=%b resp=%h expected all 0", BUSY, DONE, RESP);
        end
        seen = 0;
        repeat (3) begin
            @(posedge CLK);
            #1;
            if (DONE) seen++;
        end
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 26; i >= 20; i--) begin
            strobe(R3_OK[i]);
            if (DONE || BUSY) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_mid_no_done: got %0d DONE/BUSY cycles expected 0", seen);
        end
    endtask

    task automatic test_none();
        start_cmd(2'd0, 6'd0);
        check_result("resp_none", 136'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        start_cmd(2'd1, 6'd8);
        strobe(1'b1);
        start_cmd(2'd0, 6'd0);
        checks++;
        if ({DONE, BUSY} !== 2'b01) begin
            errors++;
            $display("FAIL start_while_busy(done,busy): got %b expected 01", {DONE, BUSY});
        end
        send_frame({88'd0, R7_OK}, 48);
        check_result("b2b_r7", {88'd0, R7_OK}, 1'b0, 1'b0, 1'b0, 1'b0);
        start_cmd(2'd2, 6'd0);
        send_frame({88'd0, R3_OK}, 48);
        check_result("b2b_r3", {88'd0, R3_OK}, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_r2();
`ifdef SD_R2_LONG_EN
        logic [119:0] cid;
        logic [135:0] frame;
        cid   = 120'h03_5344_5344_3136_4780_1234_5678_0142;
        frame = {2'b00, 6'h3F, cid, crc7_of120(cid), 1'b1};
        start_cmd(2'd3, 6'd0);
        for (int i = 0; i < 3; i++) strobe(1'b1);
        send_frame(frame, 136);
        check_result("r2_long", frame, 1'b0, 1'b0, 1'b0, 1'b0);
        frame[20] = ~frame[20];
        start_cmd(2'd3, 6'd0);
        send_frame(frame, 136);
        check_result("r2_crc_err", frame, 1'b0, 1'b1, 1'b0, 1'b0);
`else
        start_cmd(2'd3, 6'd0);
        check_result("r2_disabled", 136'd0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif
    endtask

    initial begin
        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        test_reset();
        @(negedge CLK);
        RST_N = 1'b1;
        test_r7_pass();
        test_idle_ignored();
        test_crc_err();
        test_index_err();
        test_timeout();
        test_r3();
        test_reset_mid();
        test_none();
        test_back_to_back();
        test_r2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sd_cmd_resp_rx.md
Name: sd_cmd_resp_rx

Overview:
- Host-side receiver for responses on the SD CMD line; the return path for the SD command sender.
- Once armed after a command's end bit has been driven, it:
  - waits for the card's start bit, with an NCR timeout;
  - shifts in the response frame on SD clock rising-edge strobes;
  - checks framing, command index and CRC7;
  - reports the frame and status to the SD init/control FSM.

Parameters:
- NCR_MAX, 64: maximum SAMPLE_EN strobes allowed in WAIT_START before the start bit; timeout threshold.
- CNT_W, 8: width of the bit/NCR counter; must hold max(NCR_MAX, 136).

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous, active-low reset
- SAMPLE_EN  in  1  one-CLK strobe marking an SD_CLK rising edge; CMD_IN is sampled only on these cycles
- CMD_IN  in  1  CMD pad input, already synchronised
- START  in  1  one-CLK pulse that arms the receiver
- RESP_TYPE  in  2  latched on START; 0 = none, 1 = R1/R6/R7 (48-bit, CRC), 2 = R3 (48-bit, no CRC), 3 = R2 (136-bit)
- EXP_INDEX  in  6  expected command index, latched on START
- BUSY  out  1  high from the cycle after START until the DONE cycle, inclusive
- DONE  out  1  one-cycle completion pulse
- RESP  out  136  received frame, MSB first received; 48-bit frames occupy [47:0] with [135:48] = 0
- TIMEOUT  out  1  no start bit within NCR_MAX strobes
- CRC_ERR  out  1  CRC7 mismatch
- FRAME_ERR  out  1  transmission bit != 0 or end bit != 1
- INDEX_ERR  out  1  index field mismatch

Behaviour:
- Reset: state IDLE; BUSY, DONE, TIMEOUT, CRC_ERR, FRAME_ERR, INDEX_ERR = 0; RESP = 0; counters and CRC = 0.
- States: IDLE, WAIT_START, RECEIVE, REPORT.
- IDLE:
  - START latches RESP_TYPE and EXP_INDEX, clears RESP and all flags, and goes to WAIT_START.
  - Exception: RESP_TYPE = 0 goes to REPORT directly, so DONE fires one cycle after START with no flags set.
  - START while BUSY is ignored. A SAMPLE_EN in the same cycle as START is ignored.
- WAIT_START, on each SAMPLE_EN:
  - CMD_IN = 0: shift 0 into RESP, bit count = 1, go to RECEIVE.
  - Otherwise increment the NCR count. On the NCR_MAX-th strobe, set TIMEOUT and go to REPORT.
- RECEIVE, on each SAMPLE_EN:
  - Shift CMD_IN into RESP LSB and increment the bit count.
  - Feed the serial CRC7 (x^7+x^3+1, zero seed) with the bits to be covered:
    - 48-bit frames: frame bits [47:8], i.e. received bits 1..40.
    - R2: frame bits [127:8].
  - When the bit count reaches the frame length (48 or 136), evaluate the checks in the same cycle and go to REPORT.
- Checks, each flag independent:
  - FRAME_ERR: frame bit [46] (R2: [134]) != 0, or bit [0] != 1.
  - INDEX_ERR, type 1: [45:40] != EXP_INDEX.
  - INDEX_ERR, types 2/3: [45:40] (R2: [133:128]) != 6'b111111.
  - CRC_ERR, types 1/3: computed CRC != received [7:1]. Never set for type 2.
- REPORT: DONE = 1 for exactly one cycle, then IDLE.
  - DONE occurs one CLK after the end-bit or timeout SAMPLE_EN.
  - RESP and flags hold until the next accepted START.
- SAMPLE_EN is ignored in IDLE and REPORT. Counters saturate and never wrap.
- RST_N low mid-frame aborts to the reset state immediately, with no DONE.

Optional Feature:
- Macro: SD_R2_LONG_EN.
- Defined: RESP_TYPE = 3 receives a 136-bit R2 frame as described above.
- Undefined:
  - RESP[135:48] are tied to 0 and the 136-bit shift/count logic is absent.
  - RESP_TYPE = 3 on START gives DONE one cycle later with FRAME_ERR = 1 and no line sampling.

Decomposition:
- Package sd_pkg holds:
  - RESP_TYPE encodings RESP_NONE/RESP_R1/RESP_R3/RESP_R2;
  - CRC7_POLY = 7'h09;
  - frame lengths 48/136;
  - state encoding.
- One sub-module, sd_crc7: serial CRC7 with inputs clr, en, din and a 7-bit crc output. The command sender can reuse it.

Test Plan:
- R7 pass: RESP_TYPE = 1, EXP_INDEX = 8; after 5 idle-high strobes drive 48'h08_0000_01AA_13 -> DONE, RESP = 48'h080000_01AA13, all flags 0.
- CRC error: same setup, frame 48'h08_0000_01AA_15 -> CRC_ERR = 1, FRAME_ERR = 0, INDEX_ERR = 0.
- Index mismatch: EXP_INDEX = 9 with the valid R7 frame -> INDEX_ERR = 1, CRC_ERR = 0.
- Timeout: RESP_TYPE = 1, CMD_IN held 1 for 64 strobes -> TIMEOUT = 1 and DONE one CLK after the 64th strobe, RESP = 0.
- R3 plus reset: RESP_TYPE = 2, frame 48'h3F_00FF_8000_FF -> no flags, RESP matches.
  - Repeat with RST_N pulsed low after bit 20 -> BUSY drops at once, no DONE, outputs 0.
- R2 (SD_R2_LONG_EN defined): RESP_TYPE = 3, 136-bit frame 0,0,111111, then 120-bit CID with its correct CRC7, then end bit 1 -> no flags, RESP[135:0] equals the frame.
